// File: rtl/alu_issue_controller.sv
// RV32I execute-stage sequencer: accepts one OP/OP-IMM instruction at a time,
// reads the register file, issues to a registered ALU and writes the result
// back, flagging unsupported encodings and counting retired instructions.
module alu_issue_controller #(
  parameter int COUNT_WIDTH = 32,
  parameter int XLEN        = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [31:0]            instruction,
  output logic [4:0]             rf_read_addr_1,
  output logic [4:0]             rf_read_addr_2,
  input  logic [XLEN-1:0]        rf_read_data_1,
  input  logic [XLEN-1:0]        rf_read_data_2,
  output logic                   alu_enable,
  output logic [2:0]             alu_funct3,
  output logic                   alu_alt,
  output logic [XLEN-1:0]        alu_operand_1,
  output logic [XLEN-1:0]        alu_operand_2,
  input  logic [XLEN-1:0]        alu_result,
  output logic                   rf_write_enable,
  output logic [4:0]             rf_write_addr,
  output logic [XLEN-1:0]        rf_write_data,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [2:0]             funct3_s;
  logic [4:0]             rd_s;
  logic                   is_op_s;
  logic                   is_shift_s;
  logic                   legal_s;
  logic                   alt_s;
  logic [XLEN-1:0]        imm_s;
  logic [XLEN-1:0]        op2_s;

  // Only OP and OP-IMM are handled; the alternate funct7 is legal only where
  // it selects SUB/SRA (or SRAI), and immediate shifts need a clean funct7.
  function automatic logic is_legal(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    case (ins[6:0])
      OPC_OP: begin
        ok = (ins[31:25] == F7_BASE) ||
             ((ins[31:25] == F7_ALT) &&
              ((ins[14:12] == 3'b000) || (ins[14:12] == 3'b101)));
      end
      OPC_OP_IMM: begin
        case (ins[14:12])
          3'b001:  ok = (ins[31:25] == F7_BASE);
          3'b101:  ok = (ins[31:25] == F7_BASE) || (ins[31:25] == F7_ALT);
          default: ok = 1'b1;
        endcase
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Field decode and operand-2 selection from the captured instruction
  always_comb begin
    funct3_s   = instr_q[14:12];
    rd_s       = instr_q[11:7];
    is_op_s    = (instr_q[6:0] == OPC_OP);
    legal_s    = is_legal(instr_q);
    imm_s      = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
    if (is_shift_s) begin
      // Shift amounts are always the low five bits, zero-extended
      if (is_op_s) begin
        op2_s = {{(XLEN-5){1'b0}}, rf_read_data_2[4:0]};
      end else begin
        op2_s = {{(XLEN-5){1'b0}}, instr_q[24:20]};
      end
    end else if (is_op_s) begin
      op2_s = rf_read_data_2;
    end else begin
      op2_s = imm_s;
    end
    // ADDI carries imm[10] in bit 30, so only shifts may use it as alt
    if (is_op_s) begin
      alt_s = instr_q[30];
    end else if (funct3_s == 3'b101) begin
      alt_s = instr_q[30];
    end else begin
      alt_s = 1'b0;
    end
  end

  // Next-state and per-state output strobes of the issue sequencer
  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    count_d         = count_q;
    instr_ready     = 1'b0;
    alu_enable      = 1'b0;
    alu_funct3      = 3'b000;
    alu_alt         = 1'b0;
    alu_operand_1   = {XLEN{1'b0}};
    alu_operand_2   = {XLEN{1'b0}};
    rf_write_enable = 1'b0;
    rf_write_addr   = 5'd0;
    rf_write_data   = {XLEN{1'b0}};
    illegal         = 1'b0;
    rf_read_addr_1  = instr_q[19:15];
    rf_read_addr_2  = instr_q[24:20];
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instruction;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (legal_s) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        alu_enable    = 1'b1;
        alu_funct3    = funct3_s;
        alu_alt       = alt_s;
        alu_operand_1 = rf_read_data_1;
        alu_operand_2 = op2_s;
        state_d       = ST_WB;
      end
      ST_WB: begin
        rf_write_enable = (rd_s != 5'd0);
        rf_write_addr   = rd_s;
        rf_write_data   = alu_result;
        count_d         = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured instruction and retirement counter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= 32'd0;
      count_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;

endmodule
